// File: rtl/addx_pipe.sv
// addx_pipe: pipelined SPU even-pipe extended arithmetic (addx, sfx, cgx, bgx) on big-endian slot vectors.
// Optional stall support is compiled in when ADDX_STALL_EN is defined; otherwise stall is ignored.
module addx_pipe #(
  parameter int unsigned SLOT_W    = 32,
  parameter int unsigned NUM_SLOTS = 4,
  parameter int unsigned LATENCY   = 2,
  parameter int unsigned TAG_W     = 7
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  input  logic [1:0]                  op,
  input  logic [0:SLOT_W*NUM_SLOTS-1] ra,
  input  logic [0:SLOT_W*NUM_SLOTS-1] rb,
  input  logic [0:SLOT_W*NUM_SLOTS-1] rt,
  input  logic [TAG_W-1:0]            tag_in,
  input  logic                        flush,
  input  logic                        stall,
  output logic                        out_valid,
  output logic [0:SLOT_W*NUM_SLOTS-1] result,
  output logic [TAG_W-1:0]            tag_out
);

  localparam int unsigned VW  = SLOT_W * NUM_SLOTS;
  localparam int unsigned SW1 = SLOT_W + 1;

  localparam logic [1:0] OP_ADDX = 2'b00;
  localparam logic [1:0] OP_SFX  = 2'b01;
  localparam logic [1:0] OP_CGX  = 2'b10;

  logic [0:VW-1]              res_c;
  logic                       advance_c;

  logic [LATENCY-1:0]         valid_q, valid_d, valid_sh_c;
  logic [LATENCY*VW-1:0]      data_q, data_d, data_sh_c;
  logic [LATENCY*TAG_W-1:0]   tag_q, tag_d, tag_sh_c;

  // Per-slot ALU: carry/borrow-in is the slot LSB of rt, no carry crosses slots.
  for (genvar s = 0; s < NUM_SLOTS; s++) begin : g_slot
    localparam int unsigned LO = SLOT_W * s;

    logic [SLOT_W-1:0] a_c, b_c, r_c;
    logic              cin_c;
    logic [SLOT_W:0]   sum_c, dif_c;

    assign a_c   = ra[LO +: SLOT_W];
    assign b_c   = rb[LO +: SLOT_W];
    assign cin_c = rt[LO + SLOT_W - 1];
    assign sum_c = {1'b0, a_c} + {1'b0, b_c} + SW1'(cin_c);
    // Carry-out of rb + ~ra + c is exactly the bgx "no borrow" condition.
    assign dif_c = {1'b0, b_c} + {1'b0, ~a_c} + SW1'(cin_c);

    always_comb begin : slot_sel
      r_c = '0;
      case (op)
        OP_ADDX: r_c = sum_c[SLOT_W-1:0];
        OP_SFX:  r_c = dif_c[SLOT_W-1:0];
        OP_CGX:  r_c = SLOT_W'(sum_c[SLOT_W]);
        default: r_c = SLOT_W'(dif_c[SLOT_W]);
      endcase
    end

    assign res_c[LO +: SLOT_W] = r_c;
  end

`ifdef ADDX_STALL_EN
  assign advance_c = ~stall;
`else
  logic unused_stall;
  assign unused_stall = stall;
  assign advance_c    = 1'b1;
`endif

  // Shifted view of the stage chain: stage 0 in the low slice, output stage in the high slice.
  if (LATENCY == 1) begin : g_lat1
    assign valid_sh_c = in_valid;
    assign data_sh_c  = res_c;
    assign tag_sh_c   = tag_in;
  end else begin : g_latn
    assign valid_sh_c = {valid_q[LATENCY-2:0], in_valid};
    assign data_sh_c  = {data_q[(LATENCY-1)*VW-1:0], res_c};
    assign tag_sh_c   = {tag_q[(LATENCY-1)*TAG_W-1:0], tag_in};
  end

  always_comb begin : pipe_next
    valid_d = valid_q;
    data_d  = data_q;
    tag_d   = tag_q;
    if (advance_c) begin
      valid_d = valid_sh_c;
      data_d  = data_sh_c;
      tag_d   = tag_sh_c;
    end
    // Flush kills every in-flight op, including one issued this cycle; data is left alone.
    if (flush) begin
      valid_d = '0;
    end
  end

  always_ff @(posedge clk) begin : pipe_regs
    if (!rst_n) begin
      valid_q <= '0;
      data_q  <= '0;
      tag_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      tag_q   <= tag_d;
    end
  end

  assign out_valid = valid_q[LATENCY-1];
  assign result    = data_q[LATENCY*VW-1 -: VW];
  assign tag_out   = tag_q[LATENCY*TAG_W-1 -: TAG_W];

endmodule

// File: tb/tb_addx_pipe.sv
// Self-checking bench for addx_pipe: directed cases plus a randomized stream against a queue-based model.
module tb_addx_pipe;

  localparam int unsigned SW  = 32;
  localparam int unsigned NS  = 4;
  localparam int unsigned LAT = 2;
  localparam int unsigned TW  = 7;
  localparam int unsigned VW  = SW * NS;

`ifdef ADDX_STALL_EN
  localparam bit STALL_EN = 1'b1;
`else
  localparam bit STALL_EN = 1'b0;
`endif

  typedef logic [0:VW-1] vec_t;
  typedef struct {
    bit              v;
    vec_t            res;
    logic [TW-1:0]   tag;
  } ent_t;

  logic          clk = 1'b0;
  logic          rst_n, in_valid, flush, stall;
  logic [1:0]    op;
  vec_t          ra, rb, rt;
  logic [TW-1:0] tag_in;
  logic          out_valid;
  vec_t          result;
  logic [TW-1:0] tag_out;

  int   n_cmp = 0;
  int   n_bad = 0;
  ent_t pipe_q[$];
  ent_t exp_o;
  bit   exp_rst;

  logic [1:0]  d_op  [7] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd3, 2'd3};
  logic [31:0] d_ra  [7] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd3, 32'd3, 32'hFFFF_FFFF, 32'd5, 32'd5};
  logic [31:0] d_rb  [7] = '{32'd0, 32'd0, 32'd10, 32'd10, 32'd0, 32'd5, 32'd5};
  logic [31:0] d_rt  [7] = '{32'd1, 32'h8000_0000, 32'd1, 32'd0, 32'd1, 32'd1, 32'd0};
  logic [31:0] d_exp [7] = '{32'h0, 32'hFFFF_FFFF, 32'd7, 32'd6, 32'd1, 32'd1, 32'd0};

  always #5 clk = ~clk;

  addx_pipe #(.SLOT_W(SW), .NUM_SLOTS(NS), .LATENCY(LAT), .TAG_W(TW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .op(op),
    .ra(ra), .rb(rb), .rt(rt), .tag_in(tag_in), .flush(flush), .stall(stall),
    .out_valid(out_valid), .result(result), .tag_out(tag_out)
  );

  function automatic vec_t mkvec(input logic [31:0] s0, input logic [31:0] s1,
                                 input logic [31:0] s2, input logic [31:0] s3);
    mkvec = {s0, s1, s2, s3};
  endfunction

  function automatic vec_t rnd_vec();
    rnd_vec = {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Reference: plain integer arithmetic per slot, slot 0 leftmost.
  function automatic vec_t ref_model(input logic [1:0] o, input vec_t a, input vec_t b, input vec_t t);
    vec_t            r;
    longint unsigned m;
    r = '0;
    m = 64'd1 << SW;
    for (int s = 0; s < NS; s++) begin
      longint unsigned x, y, c, v;
      x = a[s*SW +: SW];
      y = b[s*SW +: SW];
      c = t[s*SW + SW - 1];
      case (o)
        2'd0:    v = (x + y + c) % m;
        2'd1:    v = (y + m - x - (1 - c)) % m;
        2'd2:    v = ((x + y + c) >= m) ? 1 : 0;
        default: v = (c != 0 ? (y >= x) : (y > x)) ? 1 : 0;
      endcase
      r[s*SW +: SW] = v[SW-1:0];
    end
    return r;
  endfunction

  // Drive one cycle and advance the ideal-delay-line model to the expected output after the edge.
  task automatic cycle(input bit r, input bit v, input logic [1:0] o, input vec_t a, input vec_t b,
                       input vec_t t, input logic [TW-1:0] tg, input bit f, input bit s);
    ent_t e;
    rst_n = r; in_valid = v; op = o; ra = a; rb = b; rt = t; tag_in = tg; flush = f; stall = s;
    @(posedge clk);
    #1;
    if (!r) begin
      pipe_q.delete();
      for (int i = 0; i < LAT - 1; i++) pipe_q.push_back('{v: 1'b0, res: '0, tag: '0});
      exp_o   = '{v: 1'b0, res: '0, tag: '0};
      exp_rst = 1'b1;
    end else if (!(STALL_EN && s && !f)) begin
      e.v   = v;
      e.res = ref_model(o, a, b, t);
      e.tag = tg;
      pipe_q.push_back(e);
      if (f) foreach (pipe_q[i]) pipe_q[i].v = 1'b0;
      exp_o   = pipe_q.pop_front();
      exp_rst = 1'b0;
    end
  endtask

  task automatic idle(input bit s);
    cycle(1'b1, 1'b0, 2'($urandom), rnd_vec(), rnd_vec(), rnd_vec(), TW'($urandom), 1'b0, s);
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++) begin
      cycle(1'b0, 1'b1, 2'($urandom), rnd_vec(), rnd_vec(), rnd_vec(), TW'($urandom), 1'b0, 1'b0);
      n_cmp++;
      if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid[%0d]: got %b expected 0", k, out_valid); end
      n_cmp++;
      if (result !== '0) begin n_bad++; $display("FAIL reset_result[%0d]: got %h expected 0", k, result); end
      n_cmp++;
      if (tag_out !== '0) begin n_bad++; $display("FAIL reset_tag[%0d]: got %h expected 0", k, tag_out); end
    end
  endtask

  task automatic test_directed();
    logic [31:0] got0;
    for (int k = 0; k < 7; k++) begin
      cycle(1'b1, 1'b1, d_op[k], mkvec(d_ra[k], 0, 0, 0), mkvec(d_rb[k], 0, 0, 0),
            mkvec(d_rt[k], 0, 0, 0), TW'(5 + k), 1'b0, 1'b0);
      n_cmp++;
      if (out_valid !== 1'b0) begin n_bad++; $display("FAIL dir_early[%0d]: got %b expected 0", k, out_valid); end
      for (int i = 0; i < LAT - 1; i++) idle(1'b0);
      got0 = result[0:31];
      n_cmp++;
      if (out_valid !== 1'b1) begin n_bad++; $display("FAIL dir_valid[%0d]: got %b expected 1", k, out_valid); end
      n_cmp++;
      if (tag_out !== TW'(5 + k)) begin n_bad++; $display("FAIL dir_tag[%0d]: got %0d expected %0d", k, tag_out, 5 + k); end
      n_cmp++;
      if (got0 !== d_exp[k]) begin n_bad++; $display("FAIL dir_slot0[%0d]: got %h expected %h", k, got0, d_exp[k]); end
      n_cmp++;
      if (result !== exp_o.res) begin n_bad++; $display("FAIL dir_model[%0d]: got %h expected %h", k, result, exp_o.res); end
    end
  endtask

  task automatic test_stream();
    int   seen, first, last;
    vec_t a, b, t;
    seen = 0; first = -1; last = -1;
    for (int k = 0; k < 4 + LAT + 1; k++) begin
      if (k == 0) begin
        cycle(1'b1, 1'b1, 2'd0, {4{32'hFFFF_FFFF}}, {4{32'd1}}, '0, TW'(20), 1'b0, 1'b0);
      end else if (k < 4) begin
        a = rnd_vec(); b = rnd_vec(); t = rnd_vec();
        cycle(1'b1, 1'b1, 2'($urandom), a, b, t, TW'(20 + k), 1'b0, 1'b0);
      end else begin
        idle(1'b0);
      end
      n_cmp++;
      if (out_valid !== exp_o.v) begin n_bad++; $display("FAIL stream_valid[%0d]: got %b expected %b", k, out_valid, exp_o.v); end
      if (out_valid === 1'b1) begin
        if (first < 0) first = k;
        last = k;
        n_cmp++;
        if (tag_out !== TW'(20 + seen)) begin n_bad++; $display("FAIL stream_order[%0d]: got %0d expected %0d", k, tag_out, 20 + seen); end
        n_cmp++;
        if (result !== exp_o.res) begin n_bad++; $display("FAIL stream_result[%0d]: got %h expected %h", k, result, exp_o.res); end
        if (seen == 0) begin
          n_cmp++;
          if (result !== '0) begin n_bad++; $display("FAIL stream_noleak: got %h expected 0", result); end
        end
        seen++;
      end
    end
    n_cmp++;
    if (seen != 4 || last - first != 3) begin
      n_bad++; $display("FAIL stream_count: got %0d valids over %0d cycles expected 4 over 4", seen, last - first + 1);
    end
  endtask

  task automatic test_flush();
    vec_t a, b, t, c_res;
    logic [1:0] o;
    bool_loop: for (int k = 0; k < 6; k++) begin
      a = rnd_vec(); b = rnd_vec(); t = rnd_vec(); o = 2'($urandom);
      if (k < 3) begin
        if (k == 2) c_res = ref_model(o, a, b, t);
        cycle(1'b1, 1'b1, o, a, b, t, TW'(40 + k), k == 1, 1'b0);
      end else begin
        idle(1'b0);
      end
      n_cmp++;
      if (out_valid !== (k == 2 + LAT - 1)) begin
        n_bad++; $display("FAIL flush_valid[%0d]: got %b expected %b", k, out_valid, k == 2 + LAT - 1);
      end
      if (k == 2 + LAT - 1) begin
        n_cmp++;
        if (tag_out !== TW'(42) || result !== c_res) begin
          n_bad++; $display("FAIL flush_survivor: got tag %0d res %h expected tag 42 res %h", tag_out, result, c_res);
        end
      end
    end
  endtask

  task automatic test_stall();
    vec_t        a, b, t, ra_res, rb_res;
    bit          ev   [7];
    logic [TW-1:0] etag [7];
    vec_t        eres [7];
    a = rnd_vec(); b = rnd_vec(); t = rnd_vec();
    ra_res = ref_model(2'd0, a, b, t);
    rb_res = ref_model(2'd2, b, a, t);
`ifdef ADDX_STALL_EN
    ev   = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    etag = '{TW'(0), TW'(50), TW'(50), TW'(50), TW'(50), TW'(51), TW'(0)};
    eres = '{'0, ra_res, ra_res, ra_res, ra_res, rb_res, '0};
`else
    ev   = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    etag = '{TW'(0), TW'(50), TW'(51), TW'(0), TW'(0), TW'(0), TW'(0)};
    eres = '{'0, ra_res, rb_res, '0, '0, '0, '0};
`endif
    for (int k = 0; k < 7; k++) begin
      if (k == 0)      cycle(1'b1, 1'b1, 2'd0, a, b, t, TW'(50), 1'b0, 1'b0);
      else if (k == 1) cycle(1'b1, 1'b1, 2'd2, b, a, t, TW'(51), 1'b0, 1'b0);
      else             idle(k >= 2 && k <= 4);
      n_cmp++;
      if (out_valid !== ev[k]) begin n_bad++; $display("FAIL stall_valid[%0d]: got %b expected %b", k, out_valid, ev[k]); end
      if (ev[k]) begin
        n_cmp++;
        if (tag_out !== etag[k] || result !== eres[k]) begin
          n_bad++; $display("FAIL stall_data[%0d]: got tag %0d res %h expected tag %0d res %h", k, tag_out, result, etag[k], eres[k]);
        end
      end
    end
  endtask

  task automatic test_random();
    bit   r, v, f, s;
    vec_t a, b, t;
    for (int k = 0; k < 400; k++) begin
      r = ($urandom_range(0, 99) != 0);
      f = ($urandom_range(0, 19) == 0);
      s = ($urandom_range(0, 4) == 0);
      v = ($urandom_range(0, 9) < 7);
      if (STALL_EN && s) v = 1'b0;
      a = rnd_vec(); t = rnd_vec();
      b = ($urandom_range(0, 3) == 0) ? a : rnd_vec();
      cycle(r, v, 2'($urandom), a, b, t, TW'($urandom), f, s);
      n_cmp++;
      if (out_valid !== exp_o.v) begin n_bad++; $display("FAIL rand_valid[%0d]: got %b expected %b", k, out_valid, exp_o.v); end
      if (exp_o.v || exp_rst) begin
        n_cmp++;
        if (result !== exp_o.res || tag_out !== exp_o.tag) begin
          n_bad++; $display("FAIL rand_data[%0d]: got tag %0d res %h expected tag %0d res %h", k, tag_out, result, exp_o.tag, exp_o.res);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_stream();
    test_flush();
    test_stall();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
